// File: rtl/jugador_pkg.sv
// Shared definitions for the player motion controller: FSM states, direction
// encoding and the default playfield bounds used by renderer and collision.
package jugador_pkg;

  localparam int unsigned JUG_ANCHO     = 10;
  localparam int unsigned JUG_X_MIN     = 215;
  localparam int unsigned JUG_X_MAX     = 425;
  localparam int unsigned JUG_X_INICIAL = 278;

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] LENTO  = 2'd1;
  localparam logic [1:0] RAPIDO = 2'd2;

  typedef enum logic [1:0] {
    DIR_NINGUNA = 2'b00,
    DIR_IZQ     = 2'b01,
    DIR_DER     = 2'b10
  } dir_t;

  // One-bit encoding of the last direction kept by the FSM
  localparam logic LADO_IZQ = 1'b0;
  localparam logic LADO_DER = 1'b1;

  function automatic dir_t decodifica_dir(input logic izq, input logic der);
    dir_t d;
    d = DIR_NINGUNA;
    if (izq && !der) d = DIR_IZQ;
    if (der && !izq) d = DIR_DER;
    return d;
  endfunction

endpackage

// File: rtl/jugador_paso.sv
// Combinational step unit: moves a position by one step in a direction and
// either saturates at or wraps to the opposite bound when it leaves the range.
module jugador_paso
  import jugador_pkg::*;
#(
  parameter int unsigned ANCHO = JUG_ANCHO,
  parameter int unsigned X_MIN = JUG_X_MIN,
  parameter int unsigned X_MAX = JUG_X_MAX
) (
  input  logic [ANCHO-1:0] pos_i,
  input  logic [ANCHO-1:0] step_i,
  input  dir_t             dir_i,
  input  logic             wrap_i,
  output logic [ANCHO-1:0] pos_o
);

  localparam int unsigned W1 = ANCHO + 1;

  logic [ANCHO:0] resta;
  logic [ANCHO:0] suma;

  // One extra bit so a left step below zero shows up as a borrow
  assign resta = {1'b0, pos_i} - {1'b0, step_i};
  assign suma  = {1'b0, pos_i} + {1'b0, step_i};

  always_comb begin
    pos_o = pos_i;
    case (dir_i)
      DIR_IZQ: begin
        if (resta[ANCHO] || (resta < W1'(X_MIN)))
          pos_o = wrap_i ? ANCHO'(X_MAX) : ANCHO'(X_MIN);
        else
          pos_o = resta[ANCHO-1:0];
      end
      DIR_DER: begin
        if (suma > W1'(X_MAX))
          pos_o = wrap_i ? ANCHO'(X_MIN) : ANCHO'(X_MAX);
        else
          pos_o = suma[ANCHO-1:0];
      end
      default: pos_o = pos_i;
    endcase
  end

endmodule

// File: rtl/jugador_param.sv
// Player horizontal-motion controller: per-frame-tick left/right movement with
// hold-to-accelerate, bound flags and saturate/wrap handling at the edges.
module jugador_param
  import jugador_pkg::*;
#(
  parameter int unsigned ANCHO      = JUG_ANCHO,
  parameter int unsigned X_INICIAL  = JUG_X_INICIAL,
  parameter int unsigned X_MIN      = JUG_X_MIN,
  parameter int unsigned X_MAX      = JUG_X_MAX,
  parameter int unsigned DX         = 2,
  parameter int unsigned DX_RAPIDO  = 4,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned MODO_WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             izq,
  input  logic             der,
  output logic [ANCHO-1:0] posicionX,
  output logic             enMin,
  output logic             enMax,
  output logic             moviendo,
  output logic             rapido
);

  localparam int unsigned CW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  if (!((X_MIN <= X_INICIAL) && (X_INICIAL <= X_MAX) &&
        (64'(X_MAX) < (64'(1) << ANCHO)))) begin : g_bad_bounds
    $error("jugador_param: illegal position bounds");
  end
  if (!((DX > 0) && (DX <= DX_RAPIDO) && (DX_RAPIDO <= X_MAX - X_MIN))) begin : g_bad_step
    $error("jugador_param: illegal step sizes");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("jugador_param: HOLD_TICKS must be at least 1");
  end

  logic [ANCHO-1:0] pos_q, pos_d;
  logic [1:0]       estado_q, estado_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lado_q, lado_d;
  logic             mov_q, mov_d;
  logic             rap_q, rap_d;

  dir_t             dir_c;
  dir_t             paso_dir;
  logic [ANCHO-1:0] paso_step;
  logic [ANCHO-1:0] paso_pos;
  logic             lado_c;
  logic [CW-1:0]    cnt_inc;

  assign dir_c   = decodifica_dir(izq, der);
  assign lado_c  = (dir_c == DIR_DER) ? LADO_DER : LADO_IZQ;
  assign cnt_inc = cnt_q + CW'(1);

  jugador_paso #(
    .ANCHO (ANCHO),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX)
  ) u_paso (
    .pos_i  (pos_q),
    .step_i (paso_step),
    .dir_i  (paso_dir),
    .wrap_i (MODO_WRAP != 0),
    .pos_o  (paso_pos)
  );

  // Next-state and step selection; nothing changes without a tick
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    lado_d    = lado_q;
    paso_dir  = DIR_NINGUNA;
    paso_step = ANCHO'(DX);
    if (tick) begin
      case (estado_q)
        REPOSO: begin
          if (dir_c != DIR_NINGUNA) begin
            paso_dir = dir_c;
            cnt_d    = CW'(1);
            lado_d   = lado_c;
            estado_d = LENTO;
          end
        end
        LENTO, RAPIDO: begin
          if (dir_c == DIR_NINGUNA) begin
            cnt_d    = '0;
            estado_d = REPOSO;
          end else if (lado_c != lado_q) begin
            paso_dir = dir_c;
            cnt_d    = CW'(1);
            lado_d   = lado_c;
            estado_d = LENTO;
          end else if (estado_q == LENTO) begin
            paso_dir = dir_c;
            cnt_d    = cnt_inc;
            if (cnt_inc >= CW'(HOLD_TICKS)) estado_d = RAPIDO;
          end else begin
            paso_dir  = dir_c;
            paso_step = ANCHO'(DX_RAPIDO);
          end
        end
        default: begin
          cnt_d    = '0;
          estado_d = REPOSO;
        end
      endcase
    end
  end

  assign pos_d = tick ? paso_pos : pos_q;
  assign mov_d = tick ? (paso_pos != pos_q) : mov_q;
  assign rap_d = (estado_d == RAPIDO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q    <= ANCHO'(X_INICIAL);
      estado_q <= REPOSO;
      cnt_q    <= '0;
      lado_q   <= LADO_IZQ;
      mov_q    <= 1'b0;
      rap_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      lado_q   <= lado_d;
      mov_q    <= mov_d;
      rap_q    <= rap_d;
    end
  end

  assign posicionX = pos_q;
  assign moviendo  = mov_q;
  assign rapido    = rap_q;
  assign enMin     = (pos_q == ANCHO'(X_MIN));
  assign enMax     = (pos_q == ANCHO'(X_MAX));

endmodule

// File: tb/tb_jugador_param.sv
// Directed bench for jugador_param: default saturating instance plus a
// wrap-mode instance started near the upper bound.
module tb_jugador_param;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       izq;
  logic       der;
  logic [9:0] pos;
  logic       en_min, en_max, mov, rap;
  logic [9:0] w_pos;
  logic       w_en_min, w_en_max, w_mov, w_rap;

  int n_checks = 0;
  int n_errors = 0;

  jugador_param dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .izq       (izq),
    .der       (der),
    .posicionX (pos),
    .enMin     (en_min),
    .enMax     (en_max),
    .moviendo  (mov),
    .rapido    (rap)
  );

  jugador_param #(.X_INICIAL(421), .MODO_WRAP(1)) dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .izq       (izq),
    .der       (der),
    .posicionX (w_pos),
    .enMin     (w_en_min),
    .enMax     (w_en_max),
    .moviendo  (w_mov),
    .rapido    (w_rap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_tick(input logic l, input logic r);
    izq  = l;
    der  = r;
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    tick  = 1'b0;
    izq   = 1'b0;
    der   = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    izq   = 1'b0;
    der   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state and no motion without tick
    check("rst_pos", 32'(pos), 278);
    check("rst_enmin", 32'(en_min), 0);
    check("rst_enmax", 32'(en_max), 0);
    check("rst_mov", 32'(mov), 0);
    check("rst_rap", 32'(rap), 0);
    der = 1'b1;
    repeat (20) @(negedge clk);
    check("notick_pos", 32'(pos), 278);

    // Spaced slow ticks, value held between ticks
    for (int i = 1; i <= 3; i++) begin
      do_tick(1'b0, 1'b1);
      check("slow_pos", 32'(pos), 32'(278 + 2 * i));
      check("slow_mov", 32'(mov), 1);
      der = 1'b0;
      repeat (4) @(negedge clk);
      check("slow_hold", 32'(pos), 32'(278 + 2 * i));
    end

    // Acceleration to fast mode, then release
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      do_tick(1'b0, 1'b1);
      check("accel_pos", 32'(pos), (i <= 8) ? 32'(278 + 2 * i) : 32'(294 + 4 * (i - 8)));
      check("accel_rap", 32'(rap), (i >= 8) ? 32'd1 : 32'd0);
    end
    do_tick(1'b0, 1'b0);
    check("release_pos", 32'(pos), 302);
    check("release_mov", 32'(mov), 0);
    check("release_rap", 32'(rap), 0);

    // Left hold into the lower bound, saturate
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      do_tick(1'b1, 1'b0);
      check("left_pos", 32'(pos), (i <= 8) ? 32'(278 - 2 * i) : 32'(262 - 4 * (i - 8)));
    end
    check("left_218", 32'(pos), 218);
    do_tick(1'b1, 1'b0);
    check("sat_pos", 32'(pos), 215);
    check("sat_enmin", 32'(en_min), 1);
    check("sat_mov", 32'(mov), 1);
    do_tick(1'b1, 1'b0);
    check("sat_hold_pos", 32'(pos), 215);
    check("sat_hold_mov", 32'(mov), 0);
    check("sat_hold_rap", 32'(rap), 1);

    // Both buttons in fast mode, then reversal from fast mode
    do_reset();
    repeat (9) do_tick(1'b0, 1'b1);
    check("both_pre_pos", 32'(pos), 298);
    check("both_pre_rap", 32'(rap), 1);
    do_tick(1'b1, 1'b1);
    check("both_pos", 32'(pos), 298);
    check("both_mov", 32'(mov), 0);
    check("both_rap", 32'(rap), 0);
    repeat (9) do_tick(1'b0, 1'b1);
    check("rev_pre_pos", 32'(pos), 318);
    check("rev_pre_rap", 32'(rap), 1);
    do_tick(1'b1, 1'b0);
    check("rev_pos", 32'(pos), 316);
    check("rev_rap", 32'(rap), 0);
    check("rev_mov", 32'(mov), 1);
    do_tick(1'b1, 1'b0);
    check("rev2_pos", 32'(pos), 314);

    // Wrap-mode instance crossing both bounds
    do_reset();
    check("wrap_rst", 32'(w_pos), 421);
    do_tick(1'b0, 1'b1);
    check("wrap_423", 32'(w_pos), 423);
    do_tick(1'b0, 1'b1);
    check("wrap_425", 32'(w_pos), 425);
    check("wrap_enmax", 32'(w_en_max), 1);
    do_tick(1'b0, 1'b1);
    check("wrap_to_min", 32'(w_pos), 215);
    check("wrap_enmin", 32'(w_en_min), 1);
    check("wrap_mov", 32'(w_mov), 1);
    do_tick(1'b1, 1'b0);
    check("wrap_to_max", 32'(w_pos), 425);

    // Asynchronous reset between edges while in fast mode
    do_reset();
    repeat (9) do_tick(1'b0, 1'b1);
    check("arst_pre_rap", 32'(rap), 1);
    check("arst_pre_pos", 32'(pos), 298);
    der = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst_pos", 32'(pos), 278);
    check("arst_rap", 32'(rap), 0);
    check("arst_mov", 32'(mov), 0);
    check("arst_wpos", 32'(w_pos), 421);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_hold", 32'(pos), 278);
    do_tick(1'b0, 1'b1);
    check("arst_after_pos", 32'(pos), 280);
    check("arst_after_rap", 32'(rap), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jugador_param.md
Name: jugador_param

Overview:
Parametrised player horizontal-motion controller for the game's VGA playfield. It moves the player position left or right once per frame tick, with configurable bounds, step sizes, a hold-to-accelerate mode and a saturate/wrap mode. Sits between the button/input conditioning logic and the sprite renderer and collision logic, and supplies position and boundary flags.

Parameters:
ANCHO, 10, width of the position register and port
X_INICIAL, 278, position loaded on reset
X_MIN, 215, lowest legal position
X_MAX, 425, highest legal position
DX, 2, slow step per tick
DX_RAPIDO, 4, fast step per tick after sustained hold
HOLD_TICKS, 8, number of consecutive same-direction ticks before fast mode
MODO_WRAP, 0, 0 = saturate at bounds, 1 = wrap to the opposite bound
Legality (checked at elaboration): X_MIN <= X_INICIAL <= X_MAX < 2^ANCHO; 0 < DX <= DX_RAPIDO <= X_MAX-X_MIN; HOLD_TICKS >= 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle frame strobe; motion is evaluated only on cycles where tick=1
izq  in  1  left request (level)
der  in  1  right request (level)
posicionX  out  ANCHO  current player position (registered)
enMin  out  1  1 when posicionX == X_MIN
enMax  out  1  1 when posicionX == X_MAX
moviendo  out  1  1 when the last tick changed posicionX (registered)
rapido  out  1  1 while in fast state

Behaviour:
- Reset (reset=0, asynchronous): posicionX=X_INICIAL, state REPOSO, hold counter=0, moviendo=0, rapido=0. Outputs enMin and enMax reflect X_INICIAL.
- All state changes occur on the clk rising edge with tick=1. With tick=0, every register holds its value. izq and der are ignored when tick=0.
- Direction decode on tick: izq&~der selects left; der&~izq selects right; both or neither selects none.
- FSM states:
  - REPOSO: on tick with a direction, move DX, set counter=1, and go to LENTO. With no direction, stay.
  - LENTO: on tick with the same direction, move DX and increment the counter. When the counter reaches HOLD_TICKS on that tick, go to RAPIDO.
  - RAPIDO: on tick with the same direction, move DX_RAPIDO.
  - From LENTO or RAPIDO, a tick with the opposite direction moves DX, sets counter=1, and goes to LENTO. A tick with no direction clears the counter, does not move, and goes to REPOSO.
- The FSM tracks the last direction in a 1-bit register.
- Arithmetic: the candidate position is computed in ANCHO+1 bits, so subtraction cannot underflow silently.
  - Left: if posicionX - step < X_MIN, the result is X_MIN (MODO_WRAP=0) or X_MAX (MODO_WRAP=1).
  - Right: if posicionX + step > X_MAX, the result is X_MAX (MODO_WRAP=0) or X_MIN (MODO_WRAP=1).
- At a bound in saturate mode, a held request keeps the FSM advancing but posicionX is unchanged, so moviendo=0.
- moviendo is updated on every tick: 1 if the new posicionX differs from the old one, otherwise 0.
- enMin and enMax are combinational compares of the posicionX register.
- rapido = (state == RAPIDO).
- Reset asserted mid-motion returns all state to reset values immediately, with no pending move.
- Latency: posicionX is valid in the cycle after the tick edge.

Decomposition:
- Shared package jugador_pkg holds:
  - the state enum (REPOSO, LENTO, RAPIDO)
  - the direction encoding
  - the default playfield constants X_MIN/X_MAX/X_INICIAL, so the renderer and collision logic share one source
- One sub-module, jugador_paso: a combinational step/clamp/wrap unit with inputs position, step, direction, and mode, and output the next position. It is reused by a future vertical-axis instance.

Test Plan:
1. Release reset with defaults -> posicionX=278, enMin=0, enMax=0, moviendo=0, rapido=0. With no tick, der=1 for 20 cycles -> posicionX stays 278.
2. der=1, 3 ticks spaced 5 cycles apart -> posicionX 280, 282, 284. Value is held between ticks; moviendo=1 after each tick.
3. der=1 for 10 ticks -> ticks 1-8 give 280…294 with rapido=1 after tick 8; ticks 9-10 give 298, 302. Then der=0 for 1 tick -> posicionX stays 302, moviendo=0, rapido=0.
4. izq=1 held from 278 -> 8 slow ticks to 262, then 11 fast ticks to 218. The next tick gives 215 with enMin=1. A further tick leaves 215 with moviendo=0.
5. izq=der=1 on a tick while in RAPIDO -> no move, state REPOSO. Reversal test: in RAPIDO moving right, press izq -> step of -2, rapido=0.
6. MODO_WRAP=1, position driven to 425 (enMax=1), der tick -> posicionX=215. Then assert reset mid-RAPIDO, asynchronously between clock edges -> posicionX=278 immediately, rapido=0.
